word_strobe_tx: RTL
===================

Name: word_strobe_tx

Overview:
- Transmit end of the strobe-qualified parallel word link. The receive end runs on clock_50 and captures a 14-bit word in any cycle where the recovered strobe is high.
- This block accepts words from a local producer through a valid/ready handshake and buffers them in a small FIFO.
- It drives each word onto data_tx, holds it stable for a programmable setup window, pulses clock_tx for exactly one cycle, then holds the word for a programmable hold window. The receiver therefore captures each word exactly once.

Parameters:
- DATA_W, 14: word width.
- FIFO_DEPTH, 4: input buffer depth in words; must be a power of 2 and at least 2.
- SETUP_CYC, 2: cycles data_tx is stable before the strobe; must be at least 1.
- HOLD_CYC, 2: cycles data_tx is stable after the strobe; must be at least 1.

Ports:
- clock_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  word from the producer.
- data_in_valid  in  1  producer has a word on data_in.
- data_in_ready  out  1  FIFO can accept a word; a push happens when valid and ready are both high.
- data_tx  out  DATA_W  word driven to the receiver; registered.
- clock_tx  out  1  one-cycle capture strobe to the receiver; registered.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- words_sent  out  16  count of strobes issued; wraps from 0xFFFF to 0x0000.

Behaviour:
- Reset values (all applied synchronously):
  - data_tx=0, clock_tx=0, words_sent=0.
  - FIFO flushed, so fifo_level=0.
  - FSM in IDLE.
  - data_in_ready=0 while reset is high.
- data_in_ready = !full && !reset, derived combinationally from registered state.
- FIFO:
  - Push when data_in_valid && data_in_ready.
  - Pop when the FSM loads a word.
  - Push and pop in the same cycle leave the level unchanged.
  - A push into an empty FIFO is not bypassed; the word is loaded on the following edge.
  - When full, ready is low and data_in is ignored.
- FSM states are IDLE, SETUP, STROBE and HOLD. A down-counter cnt times SETUP and HOLD.
  - IDLE, FIFO non-empty: data_tx <= FIFO head, pop, cnt <= SETUP_CYC-1, go to SETUP.
  - IDLE, FIFO empty: stay in IDLE; data_tx keeps its last value.
  - SETUP: when cnt==0, go to STROBE; otherwise decrement cnt.
  - STROBE: lasts exactly 1 cycle; clock_tx=1 only in this state. On exit, words_sent++, cnt <= HOLD_CYC-1, go to HOLD.
  - HOLD: when cnt==0 and the FIFO is non-empty, load the next word as IDLE does and go to SETUP (back-to-back). When cnt==0 and the FIFO is empty, go to IDLE. Otherwise decrement cnt.
- clock_tx is registered and asserted exactly while the state is STROBE.
- data_tx does not change in SETUP, STROBE or HOLD.
- Latency:
  - A push at edge k loads data_tx at edge k+1.
  - clock_tx is high during the cycle beginning at edge k+1+SETUP_CYC.
- Back-to-back word period is SETUP_CYC+1+HOLD_CYC cycles: 5 with the defaults.
- Words are strobed in push order; none are dropped or duplicated.
- Reset mid-word: the current word and any buffered words are discarded. No strobe follows the reset, and clock_tx is 0 on the first cycle after reset.
- words_sent wraps from 0xFFFF to 0 without any flag.

Test Plan:
- Single word: reset for 2 cycles, push 0x1A5C at edge k.
  - data_tx=0x1A5C from edge k+1.
  - clock_tx high for 1 cycle only, starting at edge k+3.
  - data_tx unchanged through edge k+6; words_sent=1; busy=0 afterwards.
- Back-to-back: push 0x0001, 0x3FFF and 0x2AAA on consecutive cycles.
  - Strobes spaced 5 cycles apart.
  - A model receiver (capture when clock_tx high) records 0x0001, 0x3FFF, 0x2AAA in order.
  - words_sent=3.
- Backpressure: hold valid high with incrementing data for 12 cycles.
  - ready drops once fifo_level=4.
  - No word is lost or duplicated at the receiver.
  - ready reasserts on the cycle after a pop.
- Simultaneous push/pop: FIFO at level 2, push while the FSM pops → fifo_level stays 2 and ordering is preserved.
- Reset mid-word: assert reset while in SETUP with 3 words queued.
  - Next cycle: data_tx=0, clock_tx=0, fifo_level=0, words_sent=0.
  - No strobe occurs until new pushes arrive.
- Counter wrap: stream 65537 words → words_sent reads 0x0001 and all captured data matches.

Source files
------------

// File: rtl/word_strobe_tx.sv
// Transmit end of a strobe-qualified parallel word link: buffers producer
// words in a small FIFO and sends each one with a setup window, a
// single-cycle capture strobe and a hold window.
module word_strobe_tx #(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic                            clock_50,
  input  logic                            reset,
  input  logic [DATA_W-1:0]               data_in,
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  output logic [DATA_W-1:0]               data_tx,
  output logic                            clock_tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [15:0]                     words_sent
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned CNT_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // FIFO storage and pointers
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // FSM state and next-state values
  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic [DATA_W-1:0] data_tx_n;
  logic              clock_tx_n;
  logic [15:0]       words_sent_n;

  assign full          = (level == LVL_W'(FIFO_DEPTH));
  assign empty         = (level == '0);
  assign data_in_ready = !full && !reset;
  assign push          = data_in_valid && data_in_ready;
  assign fifo_level    = level;
  assign busy          = (state != IDLE) || !empty;

  // FIFO word storage; contents need no reset since level gates reads
  always_ff @(posedge clock_50) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock_50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // FSM state register and registered link outputs
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      data_tx    <= '0;
      clock_tx   <= 1'b0;
      words_sent <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      data_tx    <= data_tx_n;
      clock_tx   <= clock_tx_n;
      words_sent <= words_sent_n;
    end
  end

  // Next-state logic: load, setup wait, strobe, hold wait
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    data_tx_n    = data_tx;
    words_sent_n = words_sent;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        if (!empty) begin
          data_tx_n = mem[rd_ptr];
          pop       = 1'b1;
          cnt_n     = CNT_W'(SETUP_CYC - 1);
          state_n   = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = STROBE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      STROBE: begin
        words_sent_n = words_sent + 16'd1;
        cnt_n        = CNT_W'(HOLD_CYC - 1);
        state_n      = HOLD;
      end
      HOLD: begin
        if (cnt == '0) begin
          if (!empty) begin
            // back-to-back: next word goes out without an IDLE cycle
            data_tx_n = mem[rd_ptr];
            pop       = 1'b1;
            cnt_n     = CNT_W'(SETUP_CYC - 1);
            state_n   = SETUP;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    clock_tx_n = (state_n == STROBE);
  end

endmodule
